// File: rtl/if_fetch_pkg.sv
// Shared constants, FSM state type and byte-assembly helper for the fetch stage.
package if_fetch_pkg;

  localparam int          ADDR_LEN         = 32;
  localparam int          INST_LEN         = 32;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic        RESET_ENABLE     = 1'b1;
  localparam int          ICACHE_LINES_DEF = 64;
  localparam int          ICACHE_IDX_W_DEF = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // Drops one byte into the little-endian lane of a 32-bit word.
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide read port between the fetch stage and the memory controller.
interface if_fetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  // Fetch stage issues requests and receives bytes.
  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  // Memory controller answers requests.
  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );

endinterface

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped instruction cache: one 32-bit word per line, combinational
// lookup, single synchronous fill port. Only valid bits are reset.
module icache_dm #(
  parameter int LINES = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit,
  output logic [31:0]      rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic [LINES-1:0] valid;

  // Fill writes tag and data together; contents need no reset because valid gates them.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      // Per-line valid flag: cleared by reset, set when that line is filled.
      always_ff @(posedge clk) begin
        if (rst)
          valid[gi] <= 1'b0;
        else if (we && (wr_idx == IDX_W'(gi)))
          valid[gi] <= 1'b1;
      end
    end
  endgenerate

  assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the pc, looks it up in a direct-mapped cache
// and, on a miss, assembles the word from four byte reads before filling the line.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_LINES = ICACHE_LINES_DEF,
  parameter int IDX_W        = ICACHE_IDX_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic          jump_en,
  input  logic [31:0]   jump_addr,
  if_fetch_if.master    mem,
  output logic [31:0]   if_pc,
  output logic [31:0]   if_inst,
  output logic          stallreq_if
);

  localparam int TAG_W = 32 - IDX_W - 2;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [1:0]   cnt_reg, cnt_next;
  logic [31:0]  buf_reg, buf_next;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic [31:0]      line_data;
  logic             cache_we;
  logic [31:0]      fill_data;
  logic             ack_ok;

  // Only stall[0] matters to this stage; the rest belong to later pipeline registers.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign idx       = pc_reg[IDX_W+1:2];
  assign tag       = pc_reg[31:IDX_W+2];
  assign ack_ok    = mem.mem_ack && (state_reg == FETCH);
  assign fill_data = {mem.mem_data, buf_reg[23:0]};
  assign if_pc     = pc_reg;

  icache_dm #(
    .LINES (ICACHE_LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_tag  (tag),
    .hit     (hit),
    .rd_data (line_data),
    .we      (cache_we),
    .wr_idx  (idx),
    .wr_tag  (tag),
    .wr_data (fill_data)
  );

  // State, pc, byte counter and assembly buffer registers.
  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      state_reg <= IDLE;
      pc_reg    <= ZERO_WORD;
      cnt_reg   <= 2'd0;
      buf_reg   <= ZERO_WORD;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      buf_reg   <= buf_next;
    end
  end

  // Next-state and output logic; a jump overrides everything, including a partial fill.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    cnt_next     = cnt_reg;
    buf_next     = buf_reg;
    mem.mem_req  = 1'b0;
    mem.mem_addr = pc_reg + {30'd0, cnt_reg};
    if_inst      = ZERO_WORD;
    stallreq_if  = 1'b0;
    cache_we     = 1'b0;

    if (rst == RESET_ENABLE) begin
      // Outputs stay quiet during reset; registers are handled by the sequential block.
    end else if (jump_en) begin
      pc_next     = jump_addr;
      state_next  = IDLE;
      cnt_next    = 2'd0;
      stallreq_if = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hit) begin
            if_inst = line_data;
            if (!stall[0])
              pc_next = pc_reg + 32'd4;
          end else begin
            stallreq_if = 1'b1;
            state_next  = FETCH;
            cnt_next    = 2'd0;
          end
        end
        FETCH: begin
          mem.mem_req = 1'b1;
          stallreq_if = 1'b1;
          if (ack_ok) begin
            buf_next = insert_byte(buf_reg, cnt_reg, mem.mem_data);
            cnt_next = cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) begin
              cache_we   = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a per-cycle vector table for fills, hits, jumps
// and eviction, then hand sequences for wait-state fills and stall holding.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  int checks = 0;
  int errors = 0;

  if_fetch_if mem_bus();

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .mem         (mem_bus),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .stallreq_if (stallreq_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall0;
    logic        jmp;
    logic [31:0] jaddr;
    logic        ack;
    logic [7:0]  data;
    logic        exp_req;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_stallreq;
  } vec_t;

  vec_t vec [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, settle, leave sampling to the caller.
  task automatic apply(input logic s0, input logic jmp, input logic [31:0] ja,
                       input logic ack, input logic [7:0] d);
    @(negedge clk);
    rst               = 1'b0;
    stall             = {5'b0, s0};
    jump_en           = jmp;
    jump_addr         = ja;
    mem_bus.mem_ack   = ack;
    mem_bus.mem_data  = d;
    #2;
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [31:0] inst,
                            input logic [31:0] pc, input logic sr);
    check({tag, " mem_req"},     {31'd0, mem_bus.mem_req}, {31'd0, req});
    check({tag, " if_inst"},     if_inst, inst);
    check({tag, " if_pc"},       if_pc, pc);
    check({tag, " stallreq_if"}, {31'd0, stallreq_if}, {31'd0, sr});
  endtask

  initial begin
    logic [7:0]  bytes6 [4];
    logic [31:0] inst6;

    // stall0 jmp jaddr ack data | req chk_addr addr inst pc stallreq
    vec[0]  = '{0, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   32'h0,        32'h0,   1}; // cold miss
    vec[1]  = '{0, 0, 32'h0,   1, 8'h13, 1, 1, 32'h0,   32'h0,        32'h0,   1};
    vec[2]  = '{0, 0, 32'h0,   1, 8'h05, 1, 1, 32'h1,   32'h0,        32'h0,   1};
    vec[3]  = '{0, 0, 32'h0,   1, 8'h10, 1, 1, 32'h2,   32'h0,        32'h0,   1};
    vec[4]  = '{0, 0, 32'h0,   1, 8'h00, 1, 1, 32'h3,   32'h0,        32'h0,   1};
    vec[5]  = '{0, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   32'h00100513, 32'h0,   0}; // hit
    vec[6]  = '{0, 1, 32'h0,   0, 8'h00, 0, 0, 32'h0,   32'h0,        32'h4,   1}; // jump to 0
    vec[7]  = '{0, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   32'h00100513, 32'h0,   0}; // rehit
    vec[8]  = '{0, 1, 32'h40,  0, 8'h00, 0, 0, 32'h0,   32'h0,        32'h4,   1};
    vec[9]  = '{0, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   32'h0,        32'h40,  1}; // miss 0x40
    vec[10] = '{0, 0, 32'h0,   1, 8'hAA, 1, 1, 32'h40,  32'h0,        32'h40,  1};
    vec[11] = '{0, 0, 32'h0,   1, 8'hBB, 1, 1, 32'h41,  32'h0,        32'h40,  1};
    vec[12] = '{0, 1, 32'h100, 0, 8'h00, 0, 0, 32'h0,   32'h0,        32'h40,  1}; // abort
    vec[13] = '{0, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   32'h0,        32'h100, 1};
    vec[14] = '{0, 0, 32'h0,   1, 8'h11, 1, 1, 32'h100, 32'h0,        32'h100, 1};
    vec[15] = '{0, 0, 32'h0,   1, 8'h22, 1, 1, 32'h101, 32'h0,        32'h100, 1};
    vec[16] = '{0, 0, 32'h0,   1, 8'h33, 1, 1, 32'h102, 32'h0,        32'h100, 1};
    vec[17] = '{0, 0, 32'h0,   1, 8'h44, 1, 1, 32'h103, 32'h0,        32'h100, 1};
    vec[18] = '{0, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   32'h44332211, 32'h100, 0}; // hit 0x100
    vec[19] = '{0, 1, 32'h40,  0, 8'h00, 0, 0, 32'h0,   32'h0,        32'h104, 1};
    vec[20] = '{0, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   32'h0,        32'h40,  1}; // no partial fill
    vec[21] = '{0, 1, 32'h0,   0, 8'h00, 0, 0, 32'h0,   32'h0,        32'h40,  1};
    vec[22] = '{0, 0, 32'h0,   0, 8'h00, 0, 0, 32'h0,   32'h0,        32'h0,   1}; // evicted

    rst              = 1'b1;
    stall            = 6'd0;
    jump_en          = 1'b0;
    jump_addr        = 32'd0;
    mem_bus.mem_ack  = 1'b0;
    mem_bus.mem_data = 8'd0;
    repeat (2) @(negedge clk);
    #2;
    check_outs("reset", 1'b0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 23; i++) begin
      apply(vec[i].stall0, vec[i].jmp, vec[i].jaddr, vec[i].ack, vec[i].data);
      check_outs($sformatf("v%0d", i), vec[i].exp_req, vec[i].exp_inst, vec[i].exp_pc,
                 vec[i].exp_stallreq);
      if (vec[i].chk_addr)
        check($sformatf("v%0d mem_addr", i), mem_bus.mem_addr, vec[i].exp_addr);
      $display("vec %0d: pc=%h inst=%h req=%0b addr=%h stallreq=%0b", i, if_pc, if_inst,
               mem_bus.mem_req, mem_bus.mem_addr, stallreq_if);
    end

    // Refill line 0 with three wait cycles before each ack.
    bytes6[0] = 8'h93; bytes6[1] = 8'h00; bytes6[2] = 8'h50; bytes6[3] = 8'h00;
    inst6     = 32'h00500093;
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        apply(1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
        check($sformatf("wait b%0d w%0d mem_req", b, w), {31'd0, mem_bus.mem_req}, 32'd1);
        check($sformatf("wait b%0d w%0d mem_addr", b, w), mem_bus.mem_addr, 32'(b));
      end
      apply(1'b0, 1'b0, 32'h0, 1'b1, bytes6[b]);
      check($sformatf("ack b%0d mem_addr", b), mem_bus.mem_addr, 32'(b));
      $display("wait-fill byte %0d addr=%h data=%h", b, mem_bus.mem_addr, bytes6[b]);
    end

    // Hold a hit under stall[0] for three cycles.
    for (int s = 0; s < 3; s++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b0, 8'h00);
      check_outs($sformatf("stall%0d", s), 1'b0, inst6, 32'h0, 1'b0);
      $display("stall cycle %0d: pc=%h inst=%h", s, if_pc, if_inst);
    end

    // Release: pc advances by exactly 4, then the miss at 4 holds it.
    apply(1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
    check_outs("release", 1'b0, inst6, 32'h0, 1'b0);
    apply(1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
    check_outs("after release", 1'b0, 32'h0, 32'h4, 1'b1);
    apply(1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
    check_outs("fetch at 4", 1'b1, 32'h0, 32'h4, 1'b1);
    check("fetch at 4 mem_addr", mem_bus.mem_addr, 32'h4);
    $display("release sequence: pc=%h req=%0b addr=%h", if_pc, mem_bus.mem_req, mem_bus.mem_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
